// File: rtl/truth_table_sweeper_pkg.sv
// rtl/truth_table_sweeper_pkg.sv - shared state encoding and helper functions for the truth-table sweeper
package truth_table_sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [15:0] bin2gray(input logic [15:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// rtl/truth_table_sweeper_hold_timer.sv - per-vector hold counter; sample marks the last hold cycle
module hold_timer
    import truth_table_sweeper_pkg::*;
#(
    parameter int HOLD_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic sample
);

    localparam int CW = (clog2(HOLD_CYCLES) < 1) ? 1 : clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Free-running between sweeps; restart aligns count 0 with the first cycle of vector 0.
    always_comb begin
        sample = (cnt_q == LAST);
        cnt_d  = cnt_q + CW'(1);
        if (restart || sample) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive stimulus sweep with mismatch counting; SWEEP_GRAY_EN selects Gray-ordered stim
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 2,
    parameter int HOLD_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] exp_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_cnt,
    output logic [N_IN-1:0]  first_fail,
    output logic             first_fail_vld
);

    localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            ffv_q, ffv_d;
    logic            start_go;
    logic            sample;
    logic            last_idx;

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (start_go),
        .sample  (sample)
    );

    always_comb begin
`ifdef SWEEP_GRAY_EN
        stim = N_IN'(bin2gray(16'(idx_q)));
`else
        stim = idx_q;
`endif
    end

    assign last_idx = &idx_q;
    // abort outranks start, and start is ignored while a sweep is running
    assign start_go = start && !abort && (state_q != DRIVE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (start_go) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (sample) begin
                    if (dut_out != exp_out) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + (N_IN+1)'(1);
                        end
                        if (!ffv_q) begin
                            ff_d  = stim;
                            ffv_d = 1'b1;
                        end
                    end
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + N_IN'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
        end
    end

    assign busy           = (state_q == DRIVE);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_fail     = ff_q;
    assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - scoreboard bench for truth_table_sweeper (binary or SWEEP_GRAY_EN build)
module tb_truth_table_sweeper;

    localparam int HOLD = 20;
    localparam int NV   = 16;

    logic       clk = 1'b0;
    logic       rst, start, abort, start2;
    logic [1:0] dut_out, exp_out, dut_out2, exp_out2;
    logic [3:0] stim, first_fail;
    logic [4:0] err_cnt;
    logic       busy, done, pass, first_fail_vld;
    logic [1:0] stim2, first_fail2;
    logic [2:0] err_cnt2;
    logic       busy2, done2, pass2, first_fail_vld2;
    logic [15:0] fault_mask = 16'h0;

    always #5 clk = ~clk;

    // golden f = s3^s2, g = s1&s0; faulty DUT flips g on masked vectors (g stuck-at-0 when g=1)
    assign exp_out  = {stim[3] ^ stim[2], stim[1] & stim[0]};
    assign dut_out  = exp_out ^ (fault_mask[stim] ? 2'b01 : 2'b00);
    assign exp_out2 = {stim2[1] ^ stim2[0], stim2[1] & stim2[0]};
    assign dut_out2 = ~exp_out2;

    truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .dut_out(dut_out), .exp_out(exp_out), .stim(stim),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail(first_fail), .first_fail_vld(first_fail_vld)
    );

    truth_table_sweeper #(.N_IN(2), .N_OUT(2), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .dut_out(dut_out2), .exp_out(exp_out2), .stim(stim2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_fail(first_fail2), .first_fail_vld(first_fail_vld2)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_stim(input int i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    typedef struct {
        int err;
        bit ffv;
        int ff;
        int done_cyc;
    } exp_t;

    // result of sampling the first n vectors in sweep order
    function automatic exp_t model(input logic [15:0] mask, input int n);
        exp_t e;
        e = '{err: 0, ffv: 0, ff: 0, done_cyc: 0};
        for (int i = 0; i < n; i++) begin
            if (mask[ref_stim(i)]) begin
                if (e.err < NV) e.err++;
                if (!e.ffv) begin
                    e.ffv = 1;
                    e.ff  = ref_stim(i);
                end
            end
        end
        return e;
    endfunction

    exp_t exp_q[$];
    int   cyc = 0;
    int   c0  = 0;
    bit   sweeping = 0;
    bit   done_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: stim order during the sweep, scoreboard pop on each rising done
    always @(negedge clk) begin
        if (sweeping && busy && ((cyc - c0) % HOLD == 0))
            chk("stim_seq", stim, ref_stim((cyc - c0) / HOLD));
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_latency", cyc, e.done_cyc);
                chk("err_cnt", err_cnt, e.err);
                chk("first_fail_vld", first_fail_vld, e.ffv);
                if (e.ffv) chk("first_fail", first_fail, e.ff);
                chk("pass", pass, (e.err == 0) ? 1 : 0);
                chk("busy_in_done", busy, 0);
            end
            sweeping = 0;
        end
        done_prev = done;
    end

    task automatic launch(input logic [15:0] mask);
        exp_t e;
        fault_mask = mask;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        e = model(mask, NV);
        e.done_cyc = c0 + NV * HOLD;
        exp_q.push_back(e);
        sweeping = 1;
    endtask

    task automatic run_sweep(input logic [15:0] mask, input int restart_at);
        launch(mask);
        for (int k = 0; k < NV * HOLD + 20 && sweeping; k++) begin
            @(negedge clk);
            start = (restart_at > 0 && k == restart_at);
        end
        start = 1'b0;
        if (sweeping) begin
            chk("sweep_timeout", 0, 1);
            sweeping = 0;
            exp_q.delete();
        end
    endtask

    initial begin
        exp_t e;
        logic [15:0] m;
        rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stim", stim, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_ffv", first_fail_vld, 0);
        rst = 1'b0;

        run_sweep(16'h0000, 0);
        run_sweep(16'h8888, 0);
        run_sweep(16'hFFFF, 0);
        for (int r = 0; r < 4; r++) begin
            m = 16'($urandom);
            run_sweep(m, (r == 1) ? int'($urandom_range(30, 250)) : 0);
        end

        // abort during vector 5
        m = 16'($urandom) | 16'h0001;
        launch(m);
        while (cyc - c0 < 100) @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        sweeping = 0;
        void'(exp_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
        e = model(m, 5);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_stim", stim, 0);
        chk("abort_err_kept", err_cnt, e.err);
        chk("abort_ff_kept", first_fail, e.ff);
        run_sweep(16'h0000, 0);

        // reset mid-sweep
        launch(16'h0001 << ref_stim(0));
        repeat (150) @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sweeping = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_stim", stim, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_ffv", first_fail_vld, 0);
        chk("midrst_ff", first_fail, 0);

        // N_IN=2, HOLD_CYCLES=1, every vector mismatching
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start2 = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 12 && !seen; k++) begin
                @(negedge clk);
                if (done2) begin
                    seen = 1;
                    chk("h1_latency", cyc - c0, 4);
                    chk("h1_err", err_cnt2, 4);
                    chk("h1_pass", pass2, 0);
                    chk("h1_ffv", first_fail_vld2, 1);
                    chk("h1_ff", first_fail2, ref_stim(0));
                end else begin
                    chk("h1_stim", stim2, ref_stim(cyc - c0));
                end
            end
            if (!seen) chk("h1_timeout", 0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
